mux_nto1_stream: RTL

//  Parametrised N-channel, W-bit registered multiplexer with a valid/ready

---
 rtl/mux_nto1_stream_if.sv | 40 ++++
 rtl/mux_nto1_stream.sv | 111 +++++++++++
 2 files changed

// File: rtl/mux_nto1_stream_if.sv
// Stream bundle for mux_nto1_stream: channel inputs, select/mode, and valid/ready output beat.
// chan_mask exists only when MUX_SCAN_MASK_EN is defined.
interface mux_nto1_stream_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] data_in;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     data_out;
    logic [SELW-1:0]      out_sel;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;
`ifdef MUX_SCAN_MASK_EN
    logic [NCH-1:0]       chan_mask;
`endif

    // A beat moves on a side when its valid and ready are both high at the rising edge;
    // the producer holds its payload stable while valid is high and ready is low.
    modport master (
        output data_in, sel, mode, in_valid, out_ready,
`ifdef MUX_SCAN_MASK_EN
        output chan_mask,
`endif
        input  in_ready, data_out, out_sel, out_err, out_valid
    );

    modport slave (
        input  data_in, sel, mode, in_valid, out_ready,
`ifdef MUX_SCAN_MASK_EN
        input  chan_mask,
`endif
        output in_ready, data_out, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_nto1_stream.sv
// N-channel registered mux with valid/ready output: direct select or round-robin auto-scan.
// Define MUX_SCAN_MASK_EN to add chan_mask (scan skips masked channels, direct flags them).
module mux_nto1_stream #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    localparam int SELW = $clog2(NCH)
) (
    input logic clk,
    input logic rst,
    mux_nto1_stream_if.slave bus
);
    logic [SELW-1:0]  scan_ptr_q, scan_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_err_q, out_err_d;

    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] ch_data;
    logic             chan_ok;
    logic             bad;
    logic             in_ready;
    logic             accept;
`ifdef MUX_SCAN_MASK_EN
    logic             mask_any;
`endif

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
        return (int'(v) == NCH - 1) ? '0 : v + SELW'(1);
    endfunction

    // Channel index for this beat; with masking, first enabled channel at or after scan_ptr.
    always_comb begin
        idx = bus.mode ? scan_ptr_q : bus.sel;
`ifdef MUX_SCAN_MASK_EN
        mask_any = |bus.chan_mask;
        if (bus.mode) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                int c;
                c = int'(scan_ptr_q) + k;
                if (c >= NCH) c = c - NCH;
                if (bus.chan_mask[c]) idx = SELW'(c);
            end
        end
`endif
    end

    // Out-of-range indices (NCH not a power of two) match no channel and come out as errors.
    always_comb begin
        ch_data = '0;
        chan_ok = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == SELW'(i)) begin
                ch_data = bus.data_in[i*WIDTH +: WIDTH];
`ifdef MUX_SCAN_MASK_EN
                chan_ok = bus.chan_mask[i];
`else
                chan_ok = 1'b1;
`endif
            end
        end
        bad = !chan_ok;
    end

    always_comb begin
        in_ready = !out_valid_q || bus.out_ready;
`ifdef MUX_SCAN_MASK_EN
        if (bus.mode && !mask_any) in_ready = 1'b0;
`endif
        accept = bus.in_valid && in_ready;
    end

    always_comb begin
        scan_ptr_d  = scan_ptr_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            data_out_d  = bad ? '0 : ch_data;
            out_sel_d   = idx;
            out_err_d   = bad;
            if (bus.mode) scan_ptr_d = wrap_inc(idx);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr_q  <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            scan_ptr_q  <= scan_ptr_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            out_sel_q   <= out_sel_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_err   = out_err_q;
endmodule
